reg_scan_stats: RTL and testbench

Parametrised scan engine that owns a DEPTH×DATA_W register file and, on a `go` request, walks every entry once. It computes sum, min, max and a threshold hit count, and optionally rewrites entries at or above a threshold. It is the generalised successor of the fixed 16×8 min/sum scanner, adding configurable width and depth, a runtime threshold, max and hit count, selectable write-back modes, and a host load port. It sits beside the datapath as a self-contained statistics/normalisation unit.

---
 rtl/scan_pkg.sv | 21 ++
 rtl/regfile_dp.sv | 36 +++
 rtl/reg_scan_stats.sv | 168 ++++++++++++++++
 tb/tb_reg_scan_stats.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared FSM states and write-back mode encodings for reg_scan_stats
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EV,
    WR,
    DONE
  } state_t;

  localparam logic [1:0] MODE_STATS = 2'b00;
  localparam logic [1:0] MODE_SUB   = 2'b01;
  localparam logic [1:0] MODE_CLR   = 2'b10;

  // Only subtract and clear rewrite entries; the spare code behaves as stats-only.
  function automatic logic is_wb(input logic [1:0] m);
    return (m == MODE_SUB) || (m == MODE_CLR);
  endfunction

endpackage

// File: rtl/regfile_dp.sv
// rtl/regfile_dp.sv - register file with one registered read port, one write port and sync clear
module regfile_dp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear wins over a same-cycle write; read data is held while rd_en is low.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/reg_scan_stats.sv
// rtl/reg_scan_stats.sv - scan engine computing sum/min/max/hit count with optional write-back
module reg_scan_stats
  import scan_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int SUM_W  = DATA_W + ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              go,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] thresh,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] min,
  output logic [DATA_W-1:0] max,
  output logic [ADDR_W:0]   hit_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   idx;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] thresh_q;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // idx is one bit wider than the address so the last-entry test cannot alias.
  assign hit  = (rd_data >= thresh_q);
  assign last = (idx == (ADDR_W + 1)'(DEPTH - 1));

  // Host loads only land in IDLE; WR owns the write port during a scan.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ld_addr;
    wr_data = ld_data;
    if (state == WR) begin
      wr_en   = 1'b1;
      wr_addr = idx[ADDR_W-1:0];
      wr_data = (mode_q == MODE_SUB) ? (rd_data - thresh_q) : '0;
    end else if (state == IDLE && ld_en) begin
      wr_en   = 1'b1;
    end
  end

  regfile_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .Clk     (Clk),
    .Rst     (Rst),
    .rd_en   (state == RD),
    .rd_addr (idx[ADDR_W-1:0]),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = RD;
        end
      end
      RD: begin
        busy      = 1'b1;
        state_nxt = EV;
      end
      EV: begin
        busy = 1'b1;
        if (hit && is_wb(mode_q)) begin
          state_nxt = WR;
        end else if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD;
        end
      end
      WR: begin
        busy      = 1'b1;
        state_nxt = last ? DONE : RD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Index, latched controls and running statistics; stats reflect original values only.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx      <= '0;
      mode_q   <= MODE_STATS;
      thresh_q <= '0;
      sum      <= '0;
      min      <= '0;
      max      <= '0;
      hit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            mode_q   <= mode;
            thresh_q <= thresh;
            idx      <= '0;
            sum      <= '0;
            min      <= '1;
            max      <= '0;
            hit_cnt  <= '0;
          end
        end
        EV: begin
          sum <= sum + SUM_W'(rd_data);
          if (rd_data < min) begin
            min <= rd_data;
          end
          if (rd_data > max) begin
            max <= rd_data;
          end
          if (hit) begin
            hit_cnt <= hit_cnt + (ADDR_W + 1)'(1);
          end
          if (!(hit && is_wb(mode_q)) && !last) begin
            idx <= idx + (ADDR_W + 1)'(1);
          end
        end
        WR: begin
          if (!last) begin
            idx <= idx + (ADDR_W + 1)'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_scan_stats.sv
// tb/tb_reg_scan_stats.sv - directed self-checking bench for reg_scan_stats
module tb_reg_scan_stats;

  logic        Clk = 1'b0;
  logic        Rst;

  logic        go, ld_en, busy, done;
  logic [1:0]  mode;
  logic [7:0]  thresh, ld_data, mn, mx;
  logic [3:0]  ld_addr;
  logic [11:0] sum;
  logic [4:0]  hit;

  logic        go4, ld_en4, busy4, done4;
  logic [1:0]  mode4;
  logic [15:0] thresh4, ld_data4, mn4, mx4;
  logic [1:0]  ld_addr4;
  logic [17:0] sum4;
  logic [2:0]  hit4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  reg_scan_stats dut (
    .Clk(Clk), .Rst(Rst), .go(go), .mode(mode), .thresh(thresh),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .done(done), .sum(sum), .min(mn), .max(mx), .hit_cnt(hit)
  );

  reg_scan_stats #(.DATA_W(16), .DEPTH(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .go(go4), .mode(mode4), .thresh(thresh4),
    .ld_en(ld_en4), .ld_addr(ld_addr4), .ld_data(ld_data4),
    .busy(busy4), .done(done4), .sum(sum4), .min(mn4), .max(mx4), .hit_cnt(hit4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic load(input bit w, input int a, input int d);
    if (w) begin
      ld_en4 = 1'b1; ld_addr4 = 2'(a); ld_data4 = 16'(d);
    end else begin
      ld_en = 1'b1; ld_addr = 4'(a); ld_data = 8'(d);
    end
    @(posedge Clk);
    @(negedge Clk);
    ld_en = 1'b0;
    ld_en4 = 1'b0;
  endtask

  // lat = cycle index of done counting the go-sampling edge's cycle as 1 edge earlier.
  task automatic scan(input bit w, input logic [1:0] m, input int th, output int lat);
    if (w) begin
      go4 = 1'b1; mode4 = m; thresh4 = 16'(th);
    end else begin
      go = 1'b1; mode = m; thresh = 8'(th);
    end
    @(posedge Clk);
    @(negedge Clk);
    go = 1'b0;
    go4 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 400; c++) begin
      if (w ? done4 : done) begin
        lat = c;
        break;
      end
      @(posedge Clk);
      @(negedge Clk);
    end
    check("scan_timeout", (lat < 0), 0);
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    int lat;
    int cyc;
    int ndone;
    int d1;
    int d2;
    Rst = 1'b1;
    go = 0; mode = 0; thresh = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
    go4 = 0; mode4 = 0; thresh4 = 0; ld_en4 = 0; ld_addr4 = 0; ld_data4 = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_min", mn, 0);
    check("rst_max", mx, 0);
    check("rst_hit", hit, 0);
    Rst = 1'b0;

    // Ramp 0..15, stats only.
    for (int i = 0; i < 16; i++) load(0, i, i);
    scan(0, 2'b00, 200, lat);
    check("t1_lat", lat, 33);
    check("t1_sum", sum, 120);
    check("t1_min", mn, 0);
    check("t1_max", mx, 15);
    check("t1_hit", hit, 0);
    scan(0, 2'b00, 200, lat);
    check("t1_unchanged_sum", sum, 120);

    // 128+i, subtract 128: every entry hits (equality included).
    for (int i = 0; i < 16; i++) load(0, i, 128 + i);
    scan(0, 2'b01, 128, lat);
    check("t2_lat", lat, 49);
    check("t2_sum", sum, 2168);
    check("t2_min", mn, 128);
    check("t2_max", mx, 143);
    check("t2_hit", hit, 16);
    scan(0, 2'b00, 8, lat);
    check("t2_rb_sum", sum, 120);
    check("t2_rb_min", mn, 0);
    check("t2_rb_max", mx, 15);
    check("t2_rb_hit", hit, 8);

    // Alternating 255/10, clear mode at thresh 255.
    for (int i = 0; i < 16; i++) load(0, i, (i % 2 == 0) ? 255 : 10);
    scan(0, 2'b10, 255, lat);
    check("t3_lat", lat, 41);
    check("t3_sum", sum, 2120);
    check("t3_min", mn, 10);
    check("t3_max", mx, 255);
    check("t3_hit", hit, 8);
    scan(0, 2'b00, 1, lat);
    check("t3_rb_sum", sum, 80);
    check("t3_rb_min", mn, 0);
    check("t3_rb_max", mx, 10);
    check("t3_rb_hit", hit, 8);

    // go held across scans, ld_en pulsed while busy.
    for (int i = 0; i < 16; i++) load(0, i, 5);
    go = 1'b1; mode = 2'b00; thresh = 0;
    @(posedge Clk);
    cyc = 0; ndone = 0; d1 = 0; d2 = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge Clk);
      cyc++;
      if (busy) begin
        ld_en = 1'b1; ld_addr = 3; ld_data = 100;
      end else begin
        ld_en = 1'b0;
      end
      if (done) begin
        ndone++;
        check("t4_sum", sum, 80);
        check("t4_hit", hit, 16);
        if (ndone == 1) d1 = cyc;
        if (ndone == 2) begin
          d2 = cyc;
          go = 1'b0;
          break;
        end
      end
      @(posedge Clk);
    end
    ld_en = 1'b0;
    go = 1'b0;
    check("t4_ndone", ndone, 2);
    check("t4_first_lat", d1, 33);
    check("t4_interval", d2 - d1, 34);
    @(posedge Clk);
    @(negedge Clk);
    scan(0, 2'b00, 0, lat);
    check("t4_rb_sum", sum, 80);
    check("t4_rb_max", mx, 5);

    // Reset during the first WR cycle of a subtract scan.
    for (int i = 0; i < 16; i++) load(0, i, 200);
    go = 1'b1; mode = 2'b01; thresh = 100;
    @(posedge Clk);
    @(negedge Clk);
    go = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_sum", sum, 0);
    check("t5_min", mn, 0);
    check("t5_max", mx, 0);
    check("t5_hit", hit, 0);
    scan(0, 2'b00, 0, lat);
    check("t5_lat", lat, 33);
    check("t5_rb_sum", sum, 0);
    check("t5_rb_max", mx, 0);
    check("t5_rb_min", mn, 0);
    check("t5_rb_hit", hit, 16);

    // Wide instance: no sum overflow at full scale.
    for (int i = 0; i < 4; i++) load(1, i, 16'hFFFF);
    scan(1, 2'b00, 0, lat);
    check("t6_lat", lat, 9);
    check("t6_sum", sum4, 18'h3FFFC);
    check("t6_hit", hit4, 4);
    check("t6_min", mn4, 16'hFFFF);
    check("t6_max", mx4, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
